// File: rtl/payload_eng_pkg.sv
// Shared constants for the payload sequence matcher: class-index width, default counter widths, never-hit rule.
// Pure declarations, no logic or state.
package payload_eng_pkg;

  localparam int CLS_IDX_W = 8;
  localparam int CLS_SPACE = 1 << CLS_IDX_W;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_OFF_W = 16;

  // A class index beyond the implemented hit bus can never match.
  function automatic logic cls_idx_live(input logic [CLS_IDX_W-1:0] idx, input int unsigned ncls);
    return 32'(idx) < ncls;
  endfunction

endpackage

// File: rtl/payload_seq_state.sv
// One chained character state: registers hit AND (predecessor OR self-loop) on each accepted byte.
// Latency 1 cycle; en=0 holds the bit, sod clears it (synchronous, active-high).
module payload_seq_state (
  input  logic clk,
  input  logic sod,
  input  logic en,
  input  logic hit,
  input  logic prev,
  input  logic loop_en,
  output logic s
);

  logic s_q;
  logic s_d;

  always_comb begin
    s_d = s_q;
    if (en) begin
      s_d = hit & (prev | (loop_en & s_q));
    end
  end

  always_ff @(posedge clk) begin
    if (sod) begin
      s_q <= 1'b0;
    end else begin
      s_q <= s_d;
    end
  end

  assign s = s_q;

endmodule

// File: rtl/payload_seq_engine.sv
// Chained character-class sequence matcher with sticky flag, pulse, saturating count; PAYLOAD_SEQ_OFFSET_EN adds first-match offset.
// Final byte accepted at t -> outputs at t+1; en=0 stalls all state, sod is the synchronous active-high reset.
module payload_seq_engine
  import payload_eng_pkg::*;
#(
  parameter int                          NSTATE    = 16,
  parameter int                          NCLS      = 128,
  parameter logic [NSTATE*CLS_IDX_W-1:0] CLS_IDX   = '0,
  parameter logic [NSTATE-1:0]           LOOP_MASK = '0,
  parameter bit                          ANCHORED  = 1'b1,
  parameter int                          CNT_W     = DEF_CNT_W,
  parameter int                          OFF_W     = DEF_OFF_W
) (
  input  logic             clk,
  input  logic             sod,
  input  logic             en,
  input  logic [NCLS-1:0]  cls_hit,
  output logic             match,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic [OFF_W-1:0] match_off,
  output logic             match_off_vld
);

  logic [CLS_SPACE-1:0] cls_ext;
  logic [NSTATE-1:0]    hit;
  logic [NSTATE-1:0]    prev;
  logic [NSTATE-1:0]    s;
  logic                 done;

  logic             first_q, first_d;
  logic             match_q, match_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Widen the hit bus to the full index space so every class index is a legal select.
  for (genvar j = 0; j < CLS_SPACE; j++) begin : g_ext
    if (j < NCLS) begin : g_live
      assign cls_ext[j] = cls_hit[j];
    end else begin : g_dead
      assign cls_ext[j] = 1'b0;
    end
  end

  for (genvar i = 0; i < NSTATE; i++) begin : g_state
    localparam logic [CLS_IDX_W-1:0] IDX = CLS_IDX[i*CLS_IDX_W +: CLS_IDX_W];

    assign hit[i] = cls_idx_live(IDX, NCLS) & cls_ext[IDX];

    if (i == 0) begin : g_head
      assign prev[i] = ANCHORED ? first_q : 1'b1;
    end else begin : g_chain
      assign prev[i] = s[i-1];
    end

    payload_seq_state u_state (
      .clk     (clk),
      .sod     (sod),
      .en      (en),
      .hit     (hit[i]),
      .prev    (prev[i]),
      .loop_en (LOOP_MASK[i]),
      .s       (s[i])
    );
  end

  // Next value of the final state, evaluated alongside the state update.
  assign done = hit[NSTATE-1] & (prev[NSTATE-1] | (LOOP_MASK[NSTATE-1] & s[NSTATE-1]));

  always_comb begin
    first_d = first_q;
    match_d = match_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    if (en) begin
      first_d = 1'b0;
      pulse_d = done;
      if (done) begin
        match_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sod) begin
      first_q <= 1'b1;
      match_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      first_q <= first_d;
      match_q <= match_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match       = match_q;
  assign match_pulse = pulse_q;
  assign match_cnt   = cnt_q;

`ifdef PAYLOAD_SEQ_OFFSET_EN
  logic [OFF_W-1:0] pos_q, pos_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             off_vld_q, off_vld_d;

  // pos_q is the offset of the byte currently presented; captured only on the first match.
  always_comb begin
    pos_d     = pos_q;
    off_d     = off_q;
    off_vld_d = off_vld_q;
    if (en) begin
      if (pos_q != '1) begin
        pos_d = pos_q + OFF_W'(1);
      end
      if (done && !off_vld_q) begin
        off_d     = pos_q;
        off_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sod) begin
      pos_q     <= '0;
      off_q     <= '0;
      off_vld_q <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      off_q     <= off_d;
      off_vld_q <= off_vld_d;
    end
  end

  assign match_off     = off_q;
  assign match_off_vld = off_vld_q;
`else
  assign match_off     = '0;
  assign match_off_vld = 1'b0;
`endif

endmodule

// File: tb/tb_payload_seq_engine.sv
// Five matcher configurations share one byte stream; a scoreboard checks every pulse, directed end-of-stream checks cover the rest.
module tb_payload_seq_engine;

  localparam int NI = 5;
  localparam int CA = 0, CB = 1, CC = 2, CX = 3, NONE = -1, ALL = -2;
`ifdef PAYLOAD_SEQ_OFFSET_EN
  localparam bit OFF_EN = 1'b1;
`else
  localparam bit OFF_EN = 1'b0;
`endif

  typedef struct {
    int cnt;
    int off;
  } exp_t;

  logic       clk;
  logic       sod;
  logic       en;
  logic [7:0] cls_hit;

  logic        match_w [NI];
  logic        pulse_w [NI];
  logic [7:0]  cnt_w   [NI];
  logic [15:0] off_w   [NI];
  logic        offv_w  [NI];
  logic [1:0]  cnt3;

  exp_t sbq [NI][$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  assign cnt_w[3] = {6'd0, cnt3};

  // 0: "abc" anchored   1: "abc" unanchored   2: "ab+c" anchored
  // 3: "ab" unanchored, 2-bit count   4: "a" then a never-hit class
  payload_seq_engine #(.NSTATE(3), .NCLS(8), .CLS_IDX({8'd2, 8'd1, 8'd0}), .LOOP_MASK(3'b000), .ANCHORED(1'b1)) u_abc (
    .clk(clk), .sod(sod), .en(en), .cls_hit(cls_hit), .match(match_w[0]), .match_pulse(pulse_w[0]),
    .match_cnt(cnt_w[0]), .match_off(off_w[0]), .match_off_vld(offv_w[0]));

  payload_seq_engine #(.NSTATE(3), .NCLS(8), .CLS_IDX({8'd2, 8'd1, 8'd0}), .LOOP_MASK(3'b000), .ANCHORED(1'b0)) u_abc_ua (
    .clk(clk), .sod(sod), .en(en), .cls_hit(cls_hit), .match(match_w[1]), .match_pulse(pulse_w[1]),
    .match_cnt(cnt_w[1]), .match_off(off_w[1]), .match_off_vld(offv_w[1]));

  payload_seq_engine #(.NSTATE(3), .NCLS(8), .CLS_IDX({8'd2, 8'd1, 8'd0}), .LOOP_MASK(3'b010), .ANCHORED(1'b1)) u_abpc (
    .clk(clk), .sod(sod), .en(en), .cls_hit(cls_hit), .match(match_w[2]), .match_pulse(pulse_w[2]),
    .match_cnt(cnt_w[2]), .match_off(off_w[2]), .match_off_vld(offv_w[2]));

  payload_seq_engine #(.NSTATE(2), .NCLS(8), .CLS_IDX({8'd1, 8'd0}), .LOOP_MASK(2'b00), .ANCHORED(1'b0), .CNT_W(2)) u_ab_sat (
    .clk(clk), .sod(sod), .en(en), .cls_hit(cls_hit), .match(match_w[3]), .match_pulse(pulse_w[3]),
    .match_cnt(cnt3), .match_off(off_w[3]), .match_off_vld(offv_w[3]));

  payload_seq_engine #(.NSTATE(2), .NCLS(8), .CLS_IDX({8'd200, 8'd0}), .LOOP_MASK(2'b00), .ANCHORED(1'b0)) u_nohit (
    .clk(clk), .sod(sod), .en(en), .cls_hit(cls_hit), .match(match_w[4]), .match_pulse(pulse_w[4]),
    .match_cnt(cnt_w[4]), .match_off(off_w[4]), .match_off_vld(offv_w[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int i, input int c, input int o);
    exp_t e;
    e.cnt = c;
    e.off = o;
    sbq[i].push_back(e);
  endtask

  task automatic step(input bit s, input bit e, input int c);
    sod = s;
    en  = e;
    if (c == ALL)       cls_hit = 8'hFF;
    else if (c == NONE) cls_hit = 8'h00;
    else                cls_hit = 8'h01 << c;
    @(posedge clk);
    #1;
  endtask

  task automatic byt(input int c);
    step(1'b0, 1'b1, c);
  endtask

  task automatic gap(input int n);
    repeat (n) step(1'b0, 1'b0, NONE);
  endtask

  task automatic seq_check(input string tag, input logic [4:0] em, input logic [4:0][7:0] ec, input logic [4:0][15:0] eo);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_match_i%0d", tag, i), match_w[i], em[i]);
      chk($sformatf("%s_cnt_i%0d", tag, i), cnt_w[i], ec[i]);
      chk($sformatf("%s_off_i%0d", tag, i), off_w[i], OFF_EN ? eo[i] : 16'd0);
      chk($sformatf("%s_offv_i%0d", tag, i), offv_w[i], OFF_EN & em[i]);
      chk($sformatf("%s_drain_i%0d", tag, i), sbq[i].size(), 0);
    end
  endtask

  // Monitor: every observed pulse must match the oldest expectation for that instance.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (pulse_w[i] === 1'b1) begin
        if (sbq[i].size() == 0) begin
          chk($sformatf("unexpected_pulse_i%0d", i), pulse_w[i], 0);
        end else begin
          mon_e = sbq[i].pop_front();
          chk($sformatf("pulse_cnt_i%0d", i), cnt_w[i], mon_e.cnt);
          chk($sformatf("pulse_match_i%0d", i), match_w[i], 1);
          chk($sformatf("pulse_off_i%0d", i), off_w[i], OFF_EN ? mon_e.off : 0);
          chk($sformatf("pulse_offv_i%0d", i), offv_w[i], OFF_EN ? 1 : 0);
        end
      end
    end
  end

  initial begin
    sod = 1'b1;
    en = 1'b0;
    cls_hit = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 1'b0, NONE);
    seq_check("reset", 5'b0, '0, '0);

    // a b c from the anchor
    step(1'b1, 1'b0, NONE);
    byt(CA);
    push(3, 1, 1);
    byt(CB);
    push(0, 1, 2); push(1, 1, 2); push(2, 1, 2);
    byt(CC);
    gap(2);
    seq_check("abc", 5'b01111, {8'd0, 8'd1, 8'd1, 8'd1, 8'd1}, {16'd0, 16'd1, 16'd2, 16'd2, 16'd2});

    // x a b c with en gaps: anchor fails, unanchored matches later
    step(1'b1, 1'b0, NONE);
    byt(CX);
    gap(1);
    byt(CA);
    push(3, 1, 2);
    byt(CB);
    gap(2);
    push(1, 1, 3);
    byt(CC);
    gap(2);
    seq_check("xabc", 5'b01010, {8'd0, 8'd1, 8'd0, 8'd1, 8'd0}, {16'd0, 16'd2, 16'd0, 16'd3, 16'd0});

    // a b b b c exercises the self-loop
    step(1'b1, 1'b0, NONE);
    byt(CA);
    push(3, 1, 1);
    byt(CB);
    byt(CB);
    byt(CB);
    push(2, 1, 4);
    byt(CC);
    gap(2);
    seq_check("abbbc", 5'b01100, {8'd0, 8'd1, 8'd1, 8'd0, 8'd0}, {16'd0, 16'd1, 16'd4, 16'd0, 16'd0});

    // a c: loop state never entered
    step(1'b1, 1'b0, NONE);
    byt(CA);
    byt(CC);
    gap(2);
    seq_check("ac", 5'b0, '0, '0);

    // (a b) x5 with gaps: 2-bit count saturates, offset stays at first match
    step(1'b1, 1'b0, NONE);
    for (int k = 0; k < 5; k++) begin
      byt(CA);
      if (k % 2 == 1) gap(1);
      push(3, (k < 2) ? k + 1 : 3, 1);
      byt(CB);
    end
    gap(2);
    seq_check("ab5", 5'b01000, {8'd0, 8'd3, 8'd0, 8'd0, 8'd0}, {16'd0, 16'd1, 16'd0, 16'd0, 16'd0});

    // a b, then sod together with a c byte: partial matches abort, the c is dropped
    step(1'b1, 1'b0, NONE);
    byt(CA);
    push(3, 1, 1);
    byt(CB);
    step(1'b1, 1'b1, CC);
    seq_check("abort", 5'b0, '0, '0);
    byt(CA);
    push(3, 1, 1);
    byt(CB);
    push(0, 1, 2); push(1, 1, 2); push(2, 1, 2);
    byt(CC);
    gap(2);
    seq_check("post_abort", 5'b01111, {8'd0, 8'd1, 8'd1, 8'd1, 8'd1}, {16'd0, 16'd1, 16'd2, 16'd2, 16'd2});

    // class index beyond the hit bus stays dead even with every class hit
    step(1'b1, 1'b0, NONE);
    byt(CA);
    push(3, 1, 1);
    byt(ALL);
    gap(2);
    seq_check("nohit", 5'b01000, {8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, {16'd0, 16'd1, 16'd0, 16'd0, 16'd0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/payload_seq_engine.md
PAYLOAD_SEQ_ENGINE -- requirements
Module: payload_seq_engine

Interface
REQ-001 SHALL have parameter NSTATE, default 16, number of chained character states (1..64).
REQ-002 SHALL have parameter NCLS, default 128, width of the character-class hit bus.
REQ-003 SHALL have parameter CLS_IDX, default all-zero, packed NSTATE x 8 bits; entry i selects the cls_hit bit for state i.
REQ-004 SHALL have parameter LOOP_MASK, default 0, NSTATE bits; bit i=1 gives state i a self-loop (one-or-more).
REQ-005 SHALL have parameter ANCHORED, default 1; 1 = pattern must start at the first byte after sod, 0 = may start at any byte.
REQ-006 SHALL have parameter CNT_W, default 8, match-counter width; OFF_W, default 16, byte-offset width.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 sod  input  1  start-of-data; reset is synchronous and active-high.
REQ-009 en  input  1  byte-valid strobe; state advances only when en=1.
REQ-010 cls_hit  input  NCLS  per-byte character-class hits, valid with en.
REQ-011 match  output  1  sticky pattern-matched flag.
REQ-012 match_pulse  output  1  one-cycle pulse per completed occurrence.
REQ-013 match_cnt  output  CNT_W  saturating occurrence count.
REQ-014 match_off, match_off_vld  output  OFF_W, 1  byte offset of first match end (only with offset feature).

Function
REQ-015 SHALL hold state vector s[NSTATE-1:0] of registered bits, one per state.
REQ-016 On en=1, s[i] SHALL load hit(i) AND (prev(i) OR (LOOP_MASK[i] AND s[i])); hit(i)=cls_hit[CLS_IDX[i]].
REQ-017 prev(0) SHALL be first_q when ANCHORED=1, constant 1 when ANCHORED=0; prev(i)=s[i-1] for i>0.
REQ-018 first_q SHALL be 1 after sod and clear on the first en=1 cycle.
REQ-019 With en=0, s, first_q, counters and outputs SHALL hold.
REQ-020 done = next value of s[NSTATE-1]; match_pulse SHALL be 1 in the cycle after an en cycle where done=1, else 0.
REQ-021 match SHALL set in the same cycle as the first match_pulse and stay 1 until sod.
REQ-022 match_cnt SHALL increment on each match_pulse, saturating at 2^CNT_W-1; self-loop final state counts each extending byte.
REQ-023 Latency: final matching byte accepted in cycle t -> match/match_pulse high at t+1.
REQ-024 CLS_IDX entries >= NCLS SHALL be treated as never-hit.

Reset
REQ-025 sod=1 SHALL clear s, match, match_pulse, match_cnt, match_off, match_off_vld, byte position to 0, set first_q=1.
REQ-026 sod=1 with en=1 SHALL discard that byte; sod mid-match SHALL abort all partial matches.

Configuration
REQ-027 Macro PAYLOAD_SEQ_OFFSET_EN defined: SHALL keep OFF_W-bit byte position (0 for first byte after sod, +1 per en, saturating at all-ones) and capture it into match_off with match_off_vld=1 on the first match only.
REQ-028 Macro undefined: SHALL omit the position counter; match_off and match_off_vld tied to 0.

Structure
REQ-029 Shared package payload_eng_pkg SHALL hold CLS_IDX field width (8), default CNT_W/OFF_W and the never-hit index rule.
REQ-030 Per-state logic SHALL be one sub-module payload_seq_state (hit, prev, loop enable, en, sod -> registered bit), instantiated NSTATE times.

Verification
REQ-031 NSTATE=3 "abc", ANCHORED=1; bytes a,b,c after sod -> match_pulse 1 cycle after c, match=1, match_cnt=1, match_off=2.
REQ-032 Same config, bytes x,a,b,c -> match stays 0 (anchor fails); ANCHORED=0 -> match=1, match_off=3.
REQ-033 "ab+c" (LOOP_MASK bit1), bytes a,b,b,b,c -> match after c; bytes a,c -> no match.
REQ-034 ANCHORED=0 "ab", CNT_W=2, stream ab repeated 5x -> match_cnt saturates at 3, match_off=1 (first only).
REQ-035 Bytes a,b then sod with en=1 carrying c -> no match, all outputs 0, first_q=1; en gaps between bytes -> result unchanged.
